// File: rtl/verify_engine.sv
// Buffers user-entered values and, on a rising start, scans them against KEY,
// then reports a one-cycle final_analysis pulse with match flag and error count.
module verify_engine #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4,
  parameter logic [DEPTH*WIDTH-1:0] KEY = 32'h7654_3210
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             din,
  input  logic                         din_valid,
  input  logic                         clear,
  input  logic                         start,
  output logic                         final_analysis,
  output logic                         match,
  output logic [$clog2(DEPTH+1)-1:0]   err_count,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         busy
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // state  | meaning
  // IDLE   | accept writes / clear, wait for rising start
  // SCAN   | compare one entry per cycle against KEY
  // REPORT | final_analysis pulse, results valid
  // HOLD   | wait for start to drop before re-arming
  typedef enum logic [1:0] {IDLE, SCAN, REPORT, HOLD} state_t;

  state_t          state, state_next;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]   idx;
  logic            start_q;
  logic            start_edge;
  logic            scan_go;
  logic            last_idx;
  logic            wr_en;
  logic            miss;
  logic [CW-1:0]   count_next;
  logic [CW-1:0]   err_next;
  logic            busy_d;
  logic            fa_d;

  assign start_edge = start & ~start_q;
  assign scan_go    = (state == IDLE) && !clear && start_edge;
  assign last_idx   = (idx == IW'(DEPTH-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (scan_go) state_next = SCAN;
      SCAN:    if (last_idx) state_next = REPORT;
      REPORT:  state_next = HOLD;
      HOLD:    if (!start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that they come straight off flops.
  always_comb begin
    busy_d = (state_next != IDLE);
    fa_d   = (state_next == REPORT);
  end

  always_comb begin
    wr_en      = (state == IDLE) && !clear && din_valid && (count != CW'(DEPTH));
    miss       = (CW'(idx) >= count) || (mem[idx] != KEY[idx*WIDTH +: WIDTH]);
    err_next   = err_count + CW'(miss);
    count_next = count;
    if ((state == IDLE) && clear) count_next = '0;
    else if (wr_en)               count_next = count + CW'(1);
  end

  // Buffer contents need no reset; count alone defines what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[count[IW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q        <= 1'b1;
      count          <= '0;
      full           <= 1'b0;
      err_count      <= '0;
      match          <= 1'b0;
      idx            <= '0;
      busy           <= 1'b0;
      final_analysis <= 1'b0;
    end else begin
      start_q        <= start;
      count          <= count_next;
      full           <= (count_next == CW'(DEPTH));
      busy           <= busy_d;
      final_analysis <= fa_d;
      if (scan_go) begin
        idx       <= '0;
        err_count <= '0;
      end else if (state == SCAN) begin
        idx       <= idx + IW'(1);
        err_count <= err_next;
        if (last_idx) match <= (err_next == '0) && (count == CW'(DEPTH));
      end
    end
  end

endmodule

// File: tb/tb_verify_engine.sv
// Directed bench for verify_engine: stimulus pushes expected scan results,
// a negedge monitor pops and checks them whenever final_analysis fires.
module tb_verify_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] din = '0;
  logic       din_valid = 1'b0;
  logic       clear = 1'b0;
  logic       start = 1'b1;
  logic       final_analysis;
  logic       match;
  logic [3:0] err_count;
  logic [3:0] count;
  logic       full;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    bit m;
    int e;
    int c;
  } exp_t;
  exp_t sb[$];

  verify_engine #(.DEPTH(8), .WIDTH(4), .KEY(32'h7654_3210)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear(clear),
    .start(start), .final_analysis(final_analysis), .match(match),
    .err_count(err_count), .count(count), .full(full), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && final_analysis) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse actual=1 required=0 cyc=%0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("match", int'(match), int'(e.m));
        check("err_count", int'(err_count), e.e);
        check("pulse_cycle", cyc, e.c);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [3:0] v);
    din = v;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Start is sampled at the next edge (E0); the pulse is seen after E0+8.
  task automatic do_scan(input bit em, input int ee, input int hold, input bit disturb);
    int n;
    sb.push_back('{em, ee, cyc + 9});
    start = 1'b1;
    if (disturb) begin
      repeat (3) tick();
      clear = 1'b1;
      din_valid = 1'b1;
      din = 4'hf;
      repeat (2) tick();
      clear = 1'b0;
      din_valid = 1'b0;
    end
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scan_timeout actual=%0d required=0", sb.size());
      sb.delete();
    end
    repeat (hold) tick();
    start = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=%0d required=done", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset released with start high: no scan.
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_pulse", int'(final_analysis), 0);
    check("rst_count", int'(count), 0);
    check("rst_err", int'(err_count), 0);
    check("rst_match", int'(match), 0);
    start = 1'b0;
    tick();

    // Asynchronous mid-cycle reset clears outputs before the next edge.
    write(4'd0);
    write(4'd1);
    check("pre_rst_count", int'(count), 2);
    #3 rst = 1'b1;
    #1;
    check("async_count", int'(count), 0);
    check("async_full", int'(full), 0);
    check("async_busy", int'(busy), 0);
    tick();
    rst = 1'b0;
    tick();

    // Exact match.
    for (int i = 0; i < 8; i++) write(4'(i));
    check("m_count", int'(count), 8);
    check("m_full", int'(full), 1);
    do_scan(1'b1, 0, 0, 1'b0);
    check("m_full_after", int'(full), 1);
    do_clear();
    check("clr_count", int'(count), 0);
    check("clr_keeps_match", int'(match), 1);

    // One mismatch at entry 3.
    write(4'd0); write(4'd1); write(4'd2); write(4'd9);
    write(4'd4); write(4'd5); write(4'd6); write(4'd7);
    do_scan(1'b0, 1, 0, 1'b0);
    do_clear();

    // Partial buffer.
    for (int i = 0; i < 5; i++) write(4'(i));
    check("p_count", int'(count), 5);
    check("p_full", int'(full), 0);
    do_scan(1'b0, 3, 0, 1'b0);
    do_clear();

    // Overflow, then writes and clear during SCAN are ignored.
    for (int i = 0; i < 10; i++) write(4'(i));
    check("o_count", int'(count), 8);
    check("o_full", int'(full), 1);
    do_scan(1'b1, 0, 0, 1'b1);
    check("o_count_after", int'(count), 8);

    // Clear together with start edge: buffer emptied, no scan.
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    repeat (3) tick();
    check("cs_busy", int'(busy), 0);
    check("cs_count", int'(count), 0);
    repeat (10) tick();
    start = 1'b0;
    tick();

    // Reset in the 4th SCAN cycle: no pulse, buffer emptied.
    for (int i = 0; i < 8; i++) write(4'(i));
    start = 1'b1;
    repeat (4) tick();
    check("ms_busy_before", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("ms_count", int'(count), 0);
    check("ms_busy", int'(busy), 0);
    tick();
    rst = 1'b0;
    repeat (15) tick();
    check("ms_idle", int'(busy), 0);
    start = 1'b0;
    tick();

    // Start held high long after a scan: single pulse; new rising start rescans.
    for (int i = 0; i < 8; i++) write(4'(i));
    do_scan(1'b1, 0, 20, 1'b0);
    check("h_idle", int'(busy), 0);
    do_scan(1'b1, 0, 0, 1'b0);

    repeat (3) tick();
    check("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/verify_engine.md
# verify_engine

Analysis stage that sits directly downstream of the quiz control FSM. It buffers user-entered values, and when the FSM raises `start_verification`, it compares the buffer element by element against a parameterised key. It then returns a one-cycle `final_analysis` pulse to the FSM, along with a match flag and an error count for display. Its sequential elements are a write-pointer buffer, a scan counter and a four-state FSM.

## Interface
- `DEPTH`, 8: number of entries in the buffer and the key.
- `WIDTH`, 4: bits per entry.
- `KEY`, 32'h7654_3210: DEPTH*WIDTH bits; entry i is `KEY[i*WIDTH +: WIDTH]`.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `din`  in  WIDTH  user value to store.
- `din_valid`  in  1  one-cycle write strobe, already edge-cleaned upstream.
- `clear`  in  1  empties the buffer; honoured in IDLE only.
- `start`  in  1  level input, driven by FSM `start_verification`; the scan triggers on its rising edge.
- `final_analysis`  out  1  one-cycle pulse that ends a scan; feeds FSM `finalAnalysis`.
- `match`  out  1  result of the last scan: all entries equal and buffer full.
- `err_count`  out  $clog2(DEPTH+1)  mismatches found in the last scan.
- `count`  out  $clog2(DEPTH+1)  entries currently stored.
- `full`  out  1  `count == DEPTH`.
- `busy`  out  1  high in SCAN, REPORT and HOLD.

## Operation
- States:
  - IDLE
  - SCAN
  - REPORT
  - HOLD
- Reset values:
  - State is IDLE.
  - `count`, `err_count`, `match`, `final_analysis`, `busy` and the scan index are 0.
  - The `start` edge register resets to 1, so a `start` held high through reset does not trigger a scan.
  - Buffer contents are don't-care.
- Start edge: `start_edge = start & ~start_q`. `start_q` samples `start` every cycle in every state.
- IDLE:
  - `clear`: `count` becomes 0. It has priority over `din_valid` and `start_edge` in the same cycle. Both of those are dropped, and the `start` edge is consumed.
  - `din_valid` and not full: `buf[count] <= din`, `count++`.
  - `din_valid` when full: ignored; no wrap, no overwrite.
  - `start_edge` with no `clear`:
    - Go to SCAN, with index 0 and `err_count` 0.
    - A `din_valid` in the same cycle is still written and is included in the scan.
- SCAN:
  - Each cycle compares entry `idx`.
  - If `idx >= count` or `buf[idx] != KEY[idx]`, `err_count++`.
  - Then `idx++`.
  - After the compare of `idx == DEPTH-1`, go to REPORT.
  - `din_valid` and `clear` are ignored.
- REPORT:
  - `final_analysis` = 1 for exactly this cycle.
  - `err_count` holds its final value.
  - `match` was registered on entry to REPORT as `(final err == 0) & (count == DEPTH)`.
  - Always proceeds to HOLD.
- HOLD:
  - Wait until `start == 0`, then go to IDLE.
  - Prevents a retrigger while the FSM still drives `start_verification`.
- Results:
  - `match` and `err_count` hold until the next scan starts.
  - `err_count` is cleared at the start edge.
  - `match` is updated only on entry to REPORT.
  - `clear` does not alter the results.
- Width rules:
  - `err_count` saturates naturally at DEPTH, so no overflow is possible.
  - `count` never exceeds DEPTH.
- Reset mid-operation: any state goes to IDLE at once. No `final_analysis` pulse is issued, and the buffer is emptied (`count` = 0).

## Timing
- All outputs are registered.
- `start` sampled high at edge E0 (with `start_q` 0): SCAN from E0.
- Compares happen at E1..E_DEPTH.
- REPORT is entered at E_DEPTH, so `final_analysis` is high from E_DEPTH to E_DEPTH+1. With DEPTH=8, the pulse starts 8 edges after the start sample.
- `match` and `err_count` are valid at E_DEPTH, coincident with `final_analysis`.
- A `din_valid` write is visible in `count` and `full` one edge after the strobe is sampled.
- From `start` low to IDLE takes one edge; the next scan needs a new rising `start`.

## Test plan
- Reset:
  - Assert `rst` asynchronously mid-cycle → all outputs 0 immediately.
  - Release with `start` = 1 → no scan; `busy` stays 0.
- Exact match:
  - Write 0,1,…,7; raise `start` → `final_analysis` is a single pulse 8 edges after the start sample.
  - `match` = 1, `err_count` = 0, `full` = 1.
- One mismatch:
  - Write 0,1,2,9,4,5,6,7; start → `match` = 0, `err_count` = 1.
- Partial buffer:
  - Write 0..4 only → `count` = 5, `full` = 0.
  - Start → `err_count` = 3, `match` = 0.
- Overflow and ignore:
  - 10 writes → `count` = 8, `full` = 1; the last two are dropped.
  - `din_valid` and `clear` during SCAN → no change to `count` or the result.
  - `clear` together with `start_edge` in IDLE → `count` = 0, no scan.
- Reset mid-scan and hold:
  - `rst` at the 4th SCAN cycle → IDLE, no pulse, `count` = 0.
  - After a completed scan, keep `start` high for 20 cycles → only one `final_analysis` pulse.
  - `start` low, then high → new scan.
